lamp_fpu_issue_ctrl: RTL and testbench



---
 rtl/lampFPU_pkg.sv | 31 +++
 rtl/lamp_fpu_rnd_ne.sv | 58 +++++
 rtl/lamp_fpu_issue_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_lamp_fpu_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lampFPU_pkg.sv
// Shared types and widths for the lampFPU issue path.
package lampFPU_pkg;

  localparam int LAMP_INTEGER_DW  = 32;
  localparam int LAMP_FLOAT_DW    = 16;
  localparam int LAMP_FLOAT_E_DW  = 8;
  localparam int LAMP_FLOAT_F_DW  = 7;
  // carry + hidden + fraction + guard/round/sticky
  localparam int LAMP_FLOAT_XF_DW = LAMP_FLOAT_F_DW + 5;

  localparam logic [LAMP_FLOAT_DW-1:0] QNAN_BF16 = 16'h7FC0;

  typedef enum logic [1:0] {
    FPOP_I2F  = 2'd0,
    FPOP_SQRT = 2'd1
  } fpuOp_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } issueState_t;

  // Opcodes 2 and 3 are reserved and answered with an error response.
  function automatic logic is_valid_op(input logic [1:0] op);
    return (op == FPOP_I2F) || (op == FPOP_SQRT);
  endfunction

endpackage

// File: rtl/lamp_fpu_rnd_ne.sv
// Round-to-nearest-even and bfloat16 packing of an unrounded {s, e, f}
// unit result, including overflow/underflow saturation.
module lamp_fpu_rnd_ne
  import lampFPU_pkg::*;
(
  input  logic                        s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]  e_i,
  input  logic [LAMP_FLOAT_XF_DW-1:0] f_i,
  input  logic                        isToRound_i,
  input  logic                        isOverflow_i,
  input  logic                        isUnderflow_i,
  output logic [LAMP_FLOAT_DW-1:0]    res_o,
  output logic                        isOverflow_o,
  output logic                        isUnderflow_o,
  output logic                        isInexact_o
);

  logic [LAMP_FLOAT_F_DW-1:0] frac;
  logic                       g_bit;
  logic                       r_bit;
  logic                       s_bit;
  logic                       round_up;
  logic [LAMP_FLOAT_F_DW:0]   frac_rnd;
  logic [LAMP_FLOAT_E_DW:0]   exp_rnd;
  logic                       exp_sat;
  logic                       is_zero;

  // Round the fraction, propagate a mantissa carry into the exponent, then saturate.
  always_comb begin
    frac     = f_i[LAMP_FLOAT_F_DW+2:3];
    g_bit    = f_i[2];
    r_bit    = f_i[1];
    s_bit    = f_i[0];
    round_up = isToRound_i & g_bit & (frac[0] | r_bit | s_bit);
    frac_rnd = {1'b0, frac} + (LAMP_FLOAT_F_DW+1)'(round_up);
    // An all-ones fraction rounding up leaves frac_rnd[6:0] at zero on its own.
    exp_rnd  = {1'b0, e_i} + (LAMP_FLOAT_E_DW+1)'(frac_rnd[LAMP_FLOAT_F_DW]);
    exp_sat  = (exp_rnd >= (LAMP_FLOAT_E_DW+1)'(9'h0FF));
    is_zero  = (e_i == '0) && (f_i == '0);

    res_o         = {s_i, exp_rnd[LAMP_FLOAT_E_DW-1:0], frac_rnd[LAMP_FLOAT_F_DW-1:0]};
    isOverflow_o  = 1'b0;
    isUnderflow_o = 1'b0;
    isInexact_o   = isToRound_i & (g_bit | r_bit | s_bit);

    if (isOverflow_i || exp_sat) begin
      res_o        = {s_i, {LAMP_FLOAT_E_DW{1'b1}}, {LAMP_FLOAT_F_DW{1'b0}}};
      isOverflow_o = 1'b1;
    end else if (isUnderflow_i) begin
      res_o         = {s_i, {(LAMP_FLOAT_DW-1){1'b0}}};
      isUnderflow_o = 1'b1;
    end else if (is_zero) begin
      res_o       = {s_i, {(LAMP_FLOAT_DW-1){1'b0}}};
      isInexact_o = 1'b0;
    end
  end

endmodule

// File: rtl/lamp_fpu_issue_ctrl.sv
// Single-issue sequencer from the core FPU request port to the lampFPU
// i2f and sqrt units. Every accepted request yields exactly one response.
//
// state | meaning
// IDLE  | ready for a request; reserved opcodes answered immediately
// ISSUE | one-cycle start strobe to the selected unit, watchdog cleared
// WAIT  | waiting for the selected unit's valid or the watchdog
// ROUND | rounded result registered into the output regs
// DONE  | response held until the consumer accepts it
module lamp_fpu_issue_ctrl
  import lampFPU_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [1:0]                  req_op_i,
  input  logic [LAMP_INTEGER_DW-1:0]  req_op1_i,
  output logic                        doI2f_o,
  output logic                        doSqrt_o,
  output logic [LAMP_INTEGER_DW-1:0]  op1_o,
  input  logic                        i2f_valid_i,
  input  logic                        i2f_s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]  i2f_e_i,
  input  logic [LAMP_FLOAT_XF_DW-1:0] i2f_f_i,
  input  logic                        i2f_isOverflow_i,
  input  logic                        i2f_isUnderflow_i,
  input  logic                        i2f_isToRound_i,
  input  logic                        sqrt_valid_i,
  input  logic                        sqrt_s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0]  sqrt_e_i,
  input  logic [LAMP_FLOAT_XF_DW-1:0] sqrt_f_i,
  input  logic                        sqrt_isOverflow_i,
  input  logic                        sqrt_isUnderflow_i,
  input  logic                        sqrt_isToRound_i,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [LAMP_FLOAT_DW-1:0]    res_o,
  output logic                        res_isOverflow_o,
  output logic                        res_isUnderflow_o,
  output logic                        res_isInexact_o,
  output logic                        res_err_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  issueState_t                 state_q;
  fpuOp_t                      op_q;
  logic [LAMP_INTEGER_DW-1:0]  op1_q;
  logic                        ready_q;
  logic                        do_i2f_q;
  logic                        do_sqrt_q;
  logic [WD_W-1:0]             wdog_q;
  logic [WD_W-1:0]             wdog_d;
  logic                        wdog_expired;

  logic                        hold_s_q;
  logic [LAMP_FLOAT_E_DW-1:0]  hold_e_q;
  logic [LAMP_FLOAT_XF_DW-1:0] hold_f_q;
  logic                        hold_rnd_q;
  logic                        hold_ovf_q;
  logic                        hold_unf_q;

  logic                        res_valid_q;
  logic [LAMP_FLOAT_DW-1:0]    res_q;
  logic                        res_ovf_q;
  logic                        res_unf_q;
  logic                        res_inex_q;
  logic                        res_err_q;

  logic                        unit_valid;
  logic                        unit_s;
  logic [LAMP_FLOAT_E_DW-1:0]  unit_e;
  logic [LAMP_FLOAT_XF_DW-1:0] unit_f;
  logic                        unit_rnd;
  logic                        unit_ovf;
  logic                        unit_unf;

  logic [LAMP_FLOAT_DW-1:0]    rnd_res;
  logic                        rnd_ovf;
  logic                        rnd_unf;
  logic                        rnd_inex;

  // Observe only the unit that was issued; the other one is ignored.
  always_comb begin
    unit_valid = i2f_valid_i;
    unit_s     = i2f_s_i;
    unit_e     = i2f_e_i;
    unit_f     = i2f_f_i;
    unit_rnd   = i2f_isToRound_i;
    unit_ovf   = i2f_isOverflow_i;
    unit_unf   = i2f_isUnderflow_i;
    if (op_q == FPOP_SQRT) begin
      unit_valid = sqrt_valid_i;
      unit_s     = sqrt_s_i;
      unit_e     = sqrt_e_i;
      unit_f     = sqrt_f_i;
      unit_rnd   = sqrt_isToRound_i;
      unit_ovf   = sqrt_isOverflow_i;
      unit_unf   = sqrt_isUnderflow_i;
    end
  end

  // Watchdog counts WAIT cycles; it expires on the TIMEOUT_CYCLES-th one.
  always_comb begin
    wdog_d       = wdog_q + WD_W'(1);
    wdog_expired = (wdog_d == WD_W'(TIMEOUT_CYCLES));
  end

  lamp_fpu_rnd_ne u_rnd (
    .s_i           (hold_s_q),
    .e_i           (hold_e_q),
    .f_i           (hold_f_q),
    .isToRound_i   (hold_rnd_q),
    .isOverflow_i  (hold_ovf_q),
    .isUnderflow_i (hold_unf_q),
    .res_o         (rnd_res),
    .isOverflow_o  (rnd_ovf),
    .isUnderflow_o (rnd_unf),
    .isInexact_o   (rnd_inex)
  );

  // Issue FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= FPOP_I2F;
      op1_q       <= '0;
      ready_q     <= 1'b0;
      do_i2f_q    <= 1'b0;
      do_sqrt_q   <= 1'b0;
      wdog_q      <= '0;
      hold_s_q    <= 1'b0;
      hold_e_q    <= '0;
      hold_f_q    <= '0;
      hold_rnd_q  <= 1'b0;
      hold_ovf_q  <= 1'b0;
      hold_unf_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
      res_ovf_q   <= 1'b0;
      res_unf_q   <= 1'b0;
      res_inex_q  <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      do_i2f_q  <= 1'b0;
      do_sqrt_q <= 1'b0;
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (ready_q && req_valid_i) begin
            ready_q <= 1'b0;
            op1_q   <= req_op1_i;
            if (is_valid_op(req_op_i)) begin
              op_q      <= fpuOp_t'(req_op_i);
              do_i2f_q  <= (req_op_i == FPOP_I2F);
              do_sqrt_q <= (req_op_i == FPOP_SQRT);
              state_q   <= ISSUE;
            end else begin
              res_q       <= '0;
              res_ovf_q   <= 1'b0;
              res_unf_q   <= 1'b0;
              res_inex_q  <= 1'b0;
              res_err_q   <= 1'b1;
              res_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        ISSUE: begin
          wdog_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (unit_valid) begin
            hold_s_q   <= unit_s;
            hold_e_q   <= unit_e;
            hold_f_q   <= unit_f;
            hold_rnd_q <= unit_rnd;
            hold_ovf_q <= unit_ovf;
            hold_unf_q <= unit_unf;
            state_q    <= ROUND;
          end else if (wdog_expired) begin
            res_q       <= QNAN_BF16;
            res_ovf_q   <= 1'b0;
            res_unf_q   <= 1'b0;
            res_inex_q  <= 1'b0;
            res_err_q   <= 1'b1;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            wdog_q <= wdog_d;
          end
        end
        ROUND: begin
          res_q       <= rnd_res;
          res_ovf_q   <= rnd_ovf;
          res_unf_q   <= rnd_unf;
          res_inex_q  <= rnd_inex;
          res_err_q   <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_q <= 1'b0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          ready_q     <= 1'b0;
          res_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o       = ready_q;
  assign doI2f_o           = do_i2f_q;
  assign doSqrt_o          = do_sqrt_q;
  assign op1_o             = op1_q;
  assign res_valid_o       = res_valid_q;
  assign res_o             = res_q;
  assign res_isOverflow_o  = res_ovf_q;
  assign res_isUnderflow_o = res_unf_q;
  assign res_isInexact_o   = res_inex_q;
  assign res_err_o         = res_err_q;

endmodule

// File: tb/tb_lamp_fpu_issue_ctrl.sv
// Bench for lamp_fpu_issue_ctrl: the bench plays both FPU units, a table of
// hand-computed vectors feeds a response scoreboard, and a few sequences
// cover watchdog, back-pressure, reserved opcodes and reset abort.
module tb_lamp_fpu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_op1_i;
  logic        doI2f_o;
  logic        doSqrt_o;
  logic [31:0] op1_o;
  logic        i2f_valid_i, i2f_s_i, i2f_isOverflow_i, i2f_isUnderflow_i, i2f_isToRound_i;
  logic [7:0]  i2f_e_i;
  logic [11:0] i2f_f_i;
  logic        sqrt_valid_i, sqrt_s_i, sqrt_isOverflow_i, sqrt_isUnderflow_i, sqrt_isToRound_i;
  logic [7:0]  sqrt_e_i;
  logic [11:0] sqrt_f_i;
  logic        res_valid_o;
  logic        res_ready_i;
  logic [15:0] res_o;
  logic        res_isOverflow_o, res_isUnderflow_o, res_isInexact_o, res_err_o;

  lamp_fpu_issue_ctrl #(.TIMEOUT_CYCLES(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .req_valid_i        (req_valid_i),
    .req_ready_o        (req_ready_o),
    .req_op_i           (req_op_i),
    .req_op1_i          (req_op1_i),
    .doI2f_o            (doI2f_o),
    .doSqrt_o           (doSqrt_o),
    .op1_o              (op1_o),
    .i2f_valid_i        (i2f_valid_i),
    .i2f_s_i            (i2f_s_i),
    .i2f_e_i            (i2f_e_i),
    .i2f_f_i            (i2f_f_i),
    .i2f_isOverflow_i   (i2f_isOverflow_i),
    .i2f_isUnderflow_i  (i2f_isUnderflow_i),
    .i2f_isToRound_i    (i2f_isToRound_i),
    .sqrt_valid_i       (sqrt_valid_i),
    .sqrt_s_i           (sqrt_s_i),
    .sqrt_e_i           (sqrt_e_i),
    .sqrt_f_i           (sqrt_f_i),
    .sqrt_isOverflow_i  (sqrt_isOverflow_i),
    .sqrt_isUnderflow_i (sqrt_isUnderflow_i),
    .sqrt_isToRound_i   (sqrt_isToRound_i),
    .res_valid_o        (res_valid_o),
    .res_ready_i        (res_ready_i),
    .res_o              (res_o),
    .res_isOverflow_o   (res_isOverflow_o),
    .res_isUnderflow_o  (res_isUnderflow_o),
    .res_isInexact_o    (res_isInexact_o),
    .res_err_o          (res_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fl = {isToRound, isOverflow, isUnderflow}; xfl = {ovf, unf, inexact, err}
  typedef struct {
    logic [1:0]  op;
    logic [31:0] op1;
    logic        s;
    logic [7:0]  e;
    logic [11:0] f;
    logic [2:0]  fl;
    int          dly;
    logic [15:0] res;
    logic [3:0]  xfl;
  } vec_t;

  typedef struct packed {
    logic [15:0] res;
    logic [3:0]  fl;
  } exp_t;

  vec_t vecs[12];
  exp_t sb_q[$];
  exp_t mon_exp;
  exp_t mon_got;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_unit(input logic sqrt, input logic v, input logic s, input logic [7:0] e,
                          input logic [11:0] f, input logic [2:0] fl);
    if (sqrt) begin
      sqrt_valid_i = v; sqrt_s_i = s; sqrt_e_i = e; sqrt_f_i = f;
      {sqrt_isToRound_i, sqrt_isOverflow_i, sqrt_isUnderflow_i} = fl;
    end else begin
      i2f_valid_i = v; i2f_s_i = s; i2f_e_i = e; i2f_f_i = f;
      {i2f_isToRound_i, i2f_isOverflow_i, i2f_isUnderflow_i} = fl;
    end
  endtask

  task automatic scramble_units();
    set_unit(1'b0, 1'b0, 1'($urandom), 8'($urandom), 12'($urandom), 3'($urandom));
    set_unit(1'b1, 1'b0, 1'($urandom), 8'($urandom), 12'($urandom), 3'($urandom));
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!req_ready_o && guard < 50) begin
      step();
      guard++;
    end
    chk("req_ready before accept", 32'(req_ready_o), 32'd1);
  endtask

  // Issue one vector and act as the unit; ends in the cycle res_valid_o is expected.
  task automatic run_vec(input vec_t v, input logic rdy);
    logic is_sqrt;
    is_sqrt = (v.op == 2'd1);
    wait_ready();
    sb_q.push_back('{v.res, v.xfl});
    req_valid_i = 1'b1;
    req_op_i    = v.op;
    req_op1_i   = v.op1;
    res_ready_i = rdy;
    step();
    req_valid_i = 1'b0;
    req_op1_i   = $urandom;
    chk("doI2f_o at c+1", 32'(doI2f_o), 32'(v.op == 2'd0));
    chk("doSqrt_o at c+1", 32'(doSqrt_o), 32'(v.op == 2'd1));
    chk("req_ready_o busy", 32'(req_ready_o), 32'd0);
    if (v.op[1]) begin
      chk("res_valid_o reserved at c+1", 32'(res_valid_o), 32'd1);
    end else begin
      chk("op1_o registered", op1_o, v.op1);
      step();
      chk("strobes clear at c+2", 32'({doI2f_o, doSqrt_o}), 32'd0);
      for (int k = 0; k < v.dly; k++) begin
        scramble_units();
        set_unit(!is_sqrt, 1'b1, 1'($urandom), 8'($urandom), 12'($urandom), 3'($urandom));
        step();
      end
      scramble_units();
      set_unit(is_sqrt, 1'b1, v.s, v.e, v.f, v.fl);
      step();
      scramble_units();
      chk("res_valid_o low in ROUND", 32'(res_valid_o), 32'd0);
      step();
      chk("res_valid_o two cycles after unit valid", 32'(res_valid_o), 32'd1);
    end
  endtask

  // Scoreboard: compare every response on its handshake cycle.
  always @(negedge clk) begin
    if (!rst && res_valid_o && res_ready_i) begin
      mon_got = '{res_o, {res_isOverflow_o, res_isUnderflow_o, res_isInexact_o, res_err_o}};
      if (sb_q.size() == 0) begin
        chk("unexpected response", 32'(mon_got), 32'hFFFFFFFF);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("response {res,ovf,unf,inex,err}", 32'(mon_got), 32'(mon_exp));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [19:0] snap;
    int early, unstable, rdy_hi, strobes;

    vecs[0]  = '{2'd0, 32'h00000005, 1'b0, 8'h81, 12'h500, 3'b100, 0, 16'h40A0, 4'b0000};
    vecs[1]  = '{2'd0, 32'h01010101, 1'b0, 8'h97, 12'h405, 3'b100, 0, 16'h4B81, 4'b0010};
    vecs[2]  = '{2'd1, 32'h00004080, 1'b0, 8'h80, 12'h404, 3'b100, 1, 16'h4000, 4'b0010};
    vecs[3]  = '{2'd1, 32'h00004000, 1'b0, 8'h80, 12'h40C, 3'b100, 0, 16'h4002, 4'b0010};
    vecs[4]  = '{2'd0, 32'h000001FF, 1'b0, 8'h80, 12'h7FE, 3'b100, 2, 16'h4080, 4'b0010};
    vecs[5]  = '{2'd1, 32'h00007F00, 1'b1, 8'hFE, 12'h7FE, 3'b100, 0, 16'hFF80, 4'b1010};
    vecs[6]  = '{2'd0, 32'h12345678, 1'b0, 8'h10, 12'h500, 3'b110, 0, 16'h7F80, 4'b1000};
    vecs[7]  = '{2'd1, 32'h00000100, 1'b1, 8'h05, 12'h500, 3'b101, 0, 16'h8000, 4'b0100};
    vecs[8]  = '{2'd1, 32'h00008000, 1'b1, 8'h00, 12'h000, 3'b100, 0, 16'h8000, 4'b0000};
    vecs[9]  = '{2'd0, 32'h00000042, 1'b0, 8'h90, 12'h6AF, 3'b000, 1, 16'h4855, 4'b0000};
    vecs[10] = '{2'd2, 32'h0000DEAD, 1'b0, 8'h00, 12'h000, 3'b000, 0, 16'h0000, 4'b0001};
    vecs[11] = '{2'd3, 32'h0000BEEF, 1'b0, 8'h00, 12'h000, 3'b000, 0, 16'h0000, 4'b0001};

    rst = 1'b1; req_valid_i = 1'b0; req_op_i = 2'd0; req_op1_i = '0; res_ready_i = 1'b0;
    scramble_units();
    repeat (3) step();
    chk("reset outputs zero",
        32'({req_ready_o, doI2f_o, doSqrt_o, res_valid_o, res_o, res_isOverflow_o,
             res_isUnderflow_o, res_isInexact_o, res_err_o}), 32'd0);
    chk("reset op1_o zero", op1_o, 32'd0);
    rst = 1'b0;
    chk("req_ready_o low as reset releases", 32'(req_ready_o), 32'd0);
    step();
    chk("req_ready_o one cycle after reset", 32'(req_ready_o), 32'd1);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], 1'b1);
      step();
    end

    // Watchdog: sqrt unit never answers.
    wait_ready();
    sb_q.push_back('{16'h7FC0, 4'b0001});
    req_valid_i = 1'b1; req_op_i = 2'd1; req_op1_i = $urandom; res_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    early = 0;
    for (int n = 1; n <= 65; n++) begin
      if (res_valid_o) early++;
      step();
    end
    chk("watchdog no response before 64 WAIT cycles", 32'(early), 32'd0);
    chk("watchdog response after WAIT cycle 64", 32'(res_valid_o), 32'd1);
    step();

    // Back-pressure: result held for 10 cycles while a new request waits.
    run_vec(vecs[0], 1'b0);
    snap = {res_o, res_isOverflow_o, res_isUnderflow_o, res_isInexact_o, res_err_o};
    req_valid_i = 1'b1; req_op_i = 2'd0; req_op1_i = 32'h77;
    unstable = 0; rdy_hi = 0; strobes = 0;
    for (int n = 0; n < 10; n++) begin
      step();
      if ({res_o, res_isOverflow_o, res_isUnderflow_o, res_isInexact_o, res_err_o} !== snap) unstable++;
      if (!res_valid_o) unstable++;
      if (req_ready_o) rdy_hi++;
      if (doI2f_o || doSqrt_o) strobes++;
    end
    chk("stall result stable", 32'(unstable), 32'd0);
    chk("stall req_ready_o low", 32'(rdy_hi), 32'd0);
    chk("stall no new strobe", 32'(strobes), 32'd0);
    req_valid_i = 1'b0;
    res_ready_i = 1'b1;
    step();
    chk("res_valid_o drops after handshake", 32'(res_valid_o), 32'd0);
    chk("req_ready_o after handshake", 32'(req_ready_o), 32'd1);
    run_vec(vecs[1], 1'b1);
    step();

    // Reset abort in WAIT followed by a stray unit valid.
    wait_ready();
    req_valid_i = 1'b1; req_op_i = 2'd0; req_op1_i = 32'd5; res_ready_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("abort clears outputs", 32'({req_ready_o, res_valid_o, doI2f_o, doSqrt_o}), 32'd0);
    step();
    rst = 1'b0;
    set_unit(1'b0, 1'b1, 1'b0, 8'h81, 12'h500, 3'b100);
    step();
    scramble_units();
    early = 0;
    for (int n = 0; n < 6; n++) begin
      if (res_valid_o) early++;
      step();
    end
    chk("no response after abort", 32'(early), 32'd0);
    run_vec(vecs[3], 1'b1);
    step();
    run_vec(vecs[9], 1'b1);
    step();

    repeat (2) step();
    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
